// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired-zero entry,
// same-cycle write bypass and a one-entry-per-clock clearing sweep.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NRD*ADDR_W-1:0]   RA,
    output logic [NRD*WIDTH-1:0]    Bus,
    input  logic [ADDR_W-1:0]       RW,
    input  logic [WIDTH-1:0]        BusW,
    input  logic                    RegWr,
    input  logic                    Clear,
    output logic                    Ready
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W:0]   LAST  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE   = (ADDR_W + 1)'(1);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   w_idx_n;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_writable;
    logic              w_wr_en;

    assign w_writable = RegWr && ((HAS_ZERO == 0) || (RW != ZADDR));
    assign Ready      = (r_state == IDLE);
    // A Clear arriving in IDLE wins over a simultaneous write.
    assign w_wr_en    = Ready && !Clear && w_writable;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= SWEEP;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        case (r_state)
            SWEEP: begin
                if (Clear) begin
                    w_idx_n = '0;
                end else begin
                    w_idx_n = r_idx + ONE;
                    if (r_idx == LAST) begin
                        w_state_n = IDLE;
                    end
                end
            end
            IDLE: begin
                if (Clear) begin
                    w_state_n = SWEEP;
                    w_idx_n   = '0;
                end
            end
            default: begin
                w_state_n = SWEEP;
                w_idx_n   = '0;
            end
        endcase
    end

    // The array has no reset; the sweep is what zeros it.
    always_ff @(posedge Clk) begin
        if (!Ready) begin
            r_mem[r_idx[ADDR_W-1:0]] <= '0;
        end else if (w_wr_en) begin
            r_mem[RW] <= BusW;
        end
    end

    always_comb begin
        Bus = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!Ready) begin
                Bus[k*WIDTH +: WIDTH] = '0;
            end else if ((HAS_ZERO != 0) && (RA[k*ADDR_W +: ADDR_W] == ZADDR)) begin
                Bus[k*WIDTH +: WIDTH] = '0;
            end else if (w_writable && (RW == RA[k*ADDR_W +: ADDR_W])) begin
                Bus[k*WIDTH +: WIDTH] = BusW;
            end else begin
                Bus[k*WIDTH +: WIDTH] = r_mem[RA[k*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default file, a no-zero-register file
// sharing its inputs, and a wide 4-port 64-bit file.
module tb_regfile_mp;

    logic        Clk;
    logic        Reset;
    logic [9:0]  RA;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic        RegWr;
    logic        Clear;
    logic [63:0] aBus;
    logic        aReady;
    logic [63:0] bBus;
    logic        bReady;

    logic         cReset;
    logic [15:0]  cRA;
    logic [255:0] cBus;
    logic [3:0]   cRW;
    logic [63:0]  cBusW;
    logic         cRegWr;
    logic         cClear;
    logic         cReady;

    int nCompared;
    int nMismatch;

    typedef struct {
        logic        regWr;
        logic [4:0]  rw;
        logic [31:0] busW;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] expA0;
        logic [31:0] expA1;
        logic [31:0] expB0;
        logic [31:0] expB1;
    } vec_t;

    vec_t vecs[10];

    regfile_mp dutA (
        .Clk(Clk), .Reset(Reset), .RA(RA), .Bus(aBus), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .Clear(Clear), .Ready(aReady)
    );

    regfile_mp #(.HAS_ZERO(0)) dutB (
        .Clk(Clk), .Reset(Reset), .RA(RA), .Bus(bBus), .RW(RW), .BusW(BusW),
        .RegWr(RegWr), .Clear(Clear), .Ready(bReady)
    );

    regfile_mp #(.WIDTH(64), .ADDR_W(4), .NRD(4)) dutC (
        .Clk(Clk), .Reset(cReset), .RA(cRA), .Bus(cBus), .RW(cRW), .BusW(cBusW),
        .RegWr(cRegWr), .Clear(cClear), .Ready(cReady)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic regWr, input logic [4:0] rw, input logic [31:0] busW,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        RegWr = regWr;
        RW    = rw;
        BusW  = busW;
        RA    = {ra1, ra0};
    endtask

    task automatic countSweep(input int edges, input string tag);
        for (int e = 1; e <= edges; e++) begin
            @(posedge Clk);
            #1;
            checkOutput($sformatf("%s ready edge %0d", tag, e), {63'd0, aReady}, {63'd0, (e == edges)});
            if (e < edges) begin
                checkOutput($sformatf("%s bus edge %0d", tag, e), aBus, 64'd0);
            end
        end
    endtask

    initial begin
        logic [3:0]  cAddr[4];
        logic [63:0] cVal[4];

        nCompared = 0;
        nMismatch = 0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd4,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd4,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd9,  32'h12345678, 5'd9,  5'd5,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd9,  32'h0,        5'd9,  5'd9,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd7,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0};
        vecs[7] = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd31, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0};
        vecs[8] = '{1'b1, 5'd31, 32'h0BADF00D, 5'd31, 5'd3,  32'h0BADF00D, 32'hA5A5A5A5, 32'h0BADF00D, 32'hA5A5A5A5};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h0,        32'h0BADF00D, 32'h0,        32'h0BADF00D};

        Reset  = 1'b1;
        Clear  = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
        cReset = 1'b1;
        cClear = 1'b0;
        cRegWr = 1'b0;
        cRW    = '0;
        cBusW  = '0;
        cRA    = '0;

        #1;
        checkOutput("reset ready", {63'd0, aReady}, 64'd0);
        checkOutput("reset bus", aBus, 64'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        countSweep(32, "reset");
        checkOutput("reset ready nozero", {63'd0, bReady}, 64'd1);

        for (int a = 0; a < 32; a++) begin
            @(negedge Clk);
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            #1;
            checkOutput($sformatf("post-sweep read %0d", a), aBus, 64'd0);
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            applyStimulus(vecs[i].regWr, vecs[i].rw, vecs[i].busW, vecs[i].ra0, vecs[i].ra1);
            #1;
            checkOutput($sformatf("vec%0d A port0", i), {32'd0, aBus[31:0]},  {32'd0, vecs[i].expA0});
            checkOutput($sformatf("vec%0d A port1", i), {32'd0, aBus[63:32]}, {32'd0, vecs[i].expA1});
            checkOutput($sformatf("vec%0d B port0", i), {32'd0, bBus[31:0]},  {32'd0, vecs[i].expB0});
            checkOutput($sformatf("vec%0d B port1", i), {32'd0, bBus[63:32]}, {32'd0, vecs[i].expB1});
        end

        // Clear colliding with a write to R7
        @(negedge Clk);
        Clear = 1'b1;
        applyStimulus(1'b1, 5'd7, 32'h1, 5'd7, 5'd3);
        #1;
        checkOutput("clear pre-edge bypass", aBus, {32'hA5A5A5A5, 32'h1});
        @(posedge Clk);
        #1;
        checkOutput("clear ready after E", {63'd0, aReady}, 64'd0);
        checkOutput("clear bus after E", aBus, 64'd0);
        @(negedge Clk);
        Clear = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
        countSweep(32, "clear");
        @(negedge Clk);
        #1;
        checkOutput("clear R7/R3 A", aBus, 64'd0);
        checkOutput("clear R7/R3 B", bBus, 64'd0);

        // Reset landing mid-sweep at idx=10
        @(negedge Clk);
        applyStimulus(1'b1, 5'd3, 32'h5A5A5A5A, 5'd3, 5'd3);
        @(negedge Clk);
        Clear = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        @(posedge Clk);
        @(negedge Clk);
        Clear = 1'b0;
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("midsweep reset ready", {63'd0, aReady}, 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        countSweep(32, "midsweep");
        @(negedge Clk);
        #1;
        checkOutput("midsweep R3", aBus, 64'd0);

        // Wide 4-port configuration
        cAddr[0] = 4'd2;
        cAddr[1] = 4'd5;
        cAddr[2] = 4'd11;
        cAddr[3] = 4'd15;
        cVal[0]  = 64'h0123456789ABCDEF;
        cVal[1]  = 64'hFEDCBA9876543210;
        cVal[2]  = 64'hCAFEF00DDEADBEEF;
        cVal[3]  = 64'h8000000000000001;
        @(negedge Clk);
        cReset = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge Clk);
            #1;
            checkOutput($sformatf("wide ready edge %0d", e), {63'd0, cReady}, {63'd0, (e == 16)});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            cRegWr = 1'b1;
            cRW    = cAddr[i];
            cBusW  = cVal[i];
        end
        @(negedge Clk);
        cRegWr = 1'b0;
        for (int k = 0; k < 4; k++) cRA[k*4 +: 4] = cAddr[k];
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("wide port%0d", k), cBus[k*64 +: 64], cVal[k]);
        end
        @(negedge Clk);
        for (int k = 0; k < 4; k++) cRA[k*4 +: 4] = cAddr[3 - k];
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("wide reversed port%0d", k), cBus[k*64 +: 64], cVal[3 - k]);
        end
        @(negedge Clk);
        cRA = {4'd5, 4'd5, 4'd0, 4'd5};
        #1;
        checkOutput("wide shared port0", cBus[63:0],    cVal[1]);
        checkOutput("wide zero port1",   cBus[127:64],  64'd0);
        checkOutput("wide shared port2", cBus[191:128], cVal[1]);
        checkOutput("wide shared port3", cBus[255:192], cVal[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the datapath. It generalises the existing 32x32 file with configurable width, depth and read-port count, a configurable hardwired-zero register, and same-cycle write-to-read bypass. It also has a self-clearing sequencer that zeros the array one entry per clock after reset or on request. It sits between the decode stage (register addresses) and the ALU/memory stages (operand buses and writeback).

## Interface
- WIDTH, 32: data width of every entry and bus.
- ADDR_W, 5: address width. DEPTH = 2**ADDR_W entries; every address is in range.
- NRD, 2: number of independent read ports (1..8).
- HAS_ZERO, 1: 1 means entry ZERO_IDX is hardwired to zero.
- ZERO_IDX, 0: index of the hardwired-zero entry. Ignored when HAS_ZERO=0.

Ports:
- Clk  in  1: single clock; all state changes on the rising edge.
- Reset  in  1: asynchronous, active-high reset.
- RA  in  NRD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- Bus  out  NRD*WIDTH: packed read data; port k uses bits [k*WIDTH +: WIDTH].
- RW  in  ADDR_W: write address.
- BusW  in  WIDTH: write data.
- RegWr  in  1: write enable.
- Clear  in  1: synchronous request to zero the whole array.
- Ready  out  1: 1 when the array is usable. 0 during a clear sweep.

## Operation
- State machine has two states: SWEEP and IDLE. A sweep index idx of ADDR_W+1 bits runs from 0 to DEPTH.
- Reset asserted (asynchronous): state=SWEEP, idx=0, Ready=0 immediately. Array contents are not reset directly.
- SWEEP:
  - Each rising edge writes entry[idx]=0 and increments idx.
  - The edge that clears entry DEPTH-1 moves the block to IDLE and sets Ready=1.
  - RegWr is ignored; no write occurs.
  - All Bus ports read 0.
  - Clear=1 restarts the sweep at idx=0.
- IDLE:
  - Clear=1 at an edge: state=SWEEP, idx=0, Ready=0. A simultaneous write is dropped.
  - Otherwise, when RegWr=1 and the target is writable, the edge stores entry[RW]=BusW.
- Writable target: RW != ZERO_IDX, or HAS_ZERO=0. Writes to the zero entry are silently dropped.
- Read, per port k, evaluated combinationally in priority order:
  1. Ready=0: Bus_k = 0.
  2. HAS_ZERO=1 and RA_k == ZERO_IDX: Bus_k = 0.
  3. Bypass, when RegWr=1, RW == RA_k and the target is writable: Bus_k = BusW.
  4. Otherwise: Bus_k = entry[RA_k].
- Ports are independent. Any number of ports may address the same entry, and all return identical data.

## Timing
- Read latency is 0 cycles (combinational from RA, RW, BusW, RegWr and state). There are no #delays in RTL.
- Write is visible through the array on the cycle after its edge, and through bypass in the same cycle.
- Reset deassertion to Ready=1 takes exactly DEPTH rising edges (32 at defaults).
- Clear sampled at edge E gives Ready=0 after E, and Ready=1 after edge E+DEPTH.
- Reset asserted mid-sweep or mid-write: the asynchronous restart overrides everything, and the in-flight write is lost.
- Reset values: Ready=0, and all Bus outputs 0.

## Test plan
- Reset sequence:
  - Pulse Reset for 2 cycles, then release.
  - Ready must stay 0 for 31 edges and go 1 on edge 32.
  - Bus must be 0 throughout.
  - After Ready=1, every address reads 0.
- Write/readback:
  - Write 0xDEADBEEF to R5.
  - On the next cycle, read R5 on port 0 and R4 on port 1.
  - Required: 0xDEADBEEF and 0 respectively.
- Bypass:
  - Hold RegWr=1, RW=9, BusW=0x12345678 with RA0=9 before the edge.
  - Bus0 must read 0x12345678 in the same cycle, and again after the edge with RegWr=0.
- Zero register:
  - Write 0xFFFFFFFF to R0 with RA0=0.
  - Bus0 must read 0 before and after the edge.
  - With HAS_ZERO=0, the same write must read back 0xFFFFFFFF.
- Clear collision:
  - With R3=0xA5A5A5A5, assert Clear and a write of 1 to R7 at the same edge.
  - Required: Ready=0 for 32 edges, R7 never written, R3 reads 0 afterwards.
  - Asserting Reset mid-sweep at idx=10 restarts the count, so Ready returns 32 edges after release.
- Wide configuration:
  - NRD=4, WIDTH=64, ADDR_W=4.
  - Write distinct values to 4 entries, then read all four on the four ports in one cycle; each port must return its own value.
  - Ready must rise 16 edges after reset.
